// File: rtl/simd_wakeup_ctrl_if.sv
// simd_wakeup_ctrl_if: issue-side inputs and mark-ready outputs between the
// wakeup controller and simd_unit. The master side drives issue/stall/clear
// and consumes the ready pulses; the slave side is the controller.
interface simd_wakeup_ctrl_if #(
  parameter int LANES  = 4,
  parameter int IDX_W  = 2,
  parameter int LANE_W = 2,
  parameter int DLY_W  = 4
);
  logic              issue_valid;
  logic [LANE_W-1:0] issue_lane;
  logic [IDX_W-1:0]  issue_rs_idx;
  logic [DLY_W-1:0]  issue_delay;
  logic              stall;
  logic              clear_err;
  logic              mark_ready_valid [LANES];
  logic [IDX_W-1:0]  mark_ready_idx   [LANES];
  logic [LANES-1:0]  lane_busy;
  logic              collision_err;

  modport master (
    output issue_valid, issue_lane, issue_rs_idx, issue_delay, stall, clear_err,
    input  mark_ready_valid, mark_ready_idx, lane_busy, collision_err
  );

  modport slave (
    input  issue_valid, issue_lane, issue_rs_idx, issue_delay, stall, clear_err,
    output mark_ready_valid, mark_ready_idx, lane_busy, collision_err
  );
endinterface

// File: rtl/simd_wakeup_ctrl.sv
// simd_wakeup_ctrl: holds one (pending, latency counter) pair per RS slot of
// every lane, counts latencies down and returns one registered mark-ready
// pulse per lane per cycle, lowest eligible RS index first.
module simd_wakeup_ctrl #(
  parameter int LANES   = 4,
  parameter int RS_SIZE = 4,
  parameter int IDX_W   = 2,
  parameter int LANE_W  = 2,
  parameter int DLY_W   = 4
) (
  input logic               clk,
  input logic               reset,
  simd_wakeup_ctrl_if.slave bus
);

  logic [RS_SIZE-1:0] r_pend [LANES];
  logic [DLY_W-1:0]   r_cnt  [LANES][RS_SIZE];
  logic               r_mrv  [LANES];
  logic [IDX_W-1:0]   r_mri  [LANES];
  logic               r_err;

  logic [RS_SIZE-1:0] w_hit     [LANES];
  logic [RS_SIZE-1:0] w_ret     [LANES];
  logic               w_sel_vld [LANES];
  logic [IDX_W-1:0]   w_sel_idx [LANES];
  logic [LANES-1:0]   w_busy;
  logic               w_coll;

  // Per-lane priority pick of the lowest-index slot that is pending with an
  // expired counter; stall blocks every pick so nothing retires.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_sel_vld[l] = 1'b0;
      w_sel_idx[l] = '0;
      w_ret[l]     = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
        if (!bus.stall && r_pend[l][i] && (r_cnt[l][i] == '0)) begin
          w_sel_vld[l] = 1'b1;
          w_sel_idx[l] = IDX_W'(i);
        end
      end
      if (w_sel_vld[l]) w_ret[l][w_sel_idx[l]] = 1'b1;
    end
  end

  // Decode the issue target; a hit on a pending slot that is not retiring
  // this edge is a collision. Lane codes at or above LANES decode to nothing.
  always_comb begin
    w_coll = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_hit[l] = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (bus.issue_valid && (bus.issue_lane == LANE_W'(l)) &&
            (bus.issue_rs_idx == IDX_W'(i)))
          w_hit[l][i] = 1'b1;
        if (w_hit[l][i] && r_pend[l][i] && !w_ret[l][i]) w_coll = 1'b1;
      end
    end
  end

  // Lane busy is the OR of that lane's registered pending bits.
  always_comb begin
    w_busy = '0;
    for (int l = 0; l < LANES; l++) w_busy[l] = |r_pend[l];
  end

  // Slot state: a new issue takes priority (it may reuse a slot retiring on
  // the same edge), otherwise retire the selected slot or count down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < LANES; l++) begin
        r_pend[l] <= '0;
        for (int i = 0; i < RS_SIZE; i++) r_cnt[l][i] <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (w_hit[l][i]) begin
            r_pend[l][i] <= 1'b1;
            r_cnt[l][i]  <= bus.issue_delay;
          end else if (w_ret[l][i]) begin
            r_pend[l][i] <= 1'b0;
          end else if (!bus.stall && r_pend[l][i] && (r_cnt[l][i] != '0)) begin
            r_cnt[l][i] <= r_cnt[l][i] - 1'b1;
          end
        end
      end
    end
  end

  // Registered ready pulses; the index holds its last value on idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < LANES; l++) begin
        r_mrv[l] <= 1'b0;
        r_mri[l] <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        r_mrv[l] <= w_sel_vld[l];
        if (w_sel_vld[l]) r_mri[l] <= w_sel_idx[l];
      end
    end
  end

  // Sticky collision flag; a new collision outranks a same-edge clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             r_err <= 1'b0;
    else if (w_coll)        r_err <= 1'b1;
    else if (bus.clear_err) r_err <= 1'b0;
  end

  assign bus.mark_ready_valid = r_mrv;
  assign bus.mark_ready_idx   = r_mri;
  assign bus.lane_busy        = w_busy;
  assign bus.collision_err    = r_err;

endmodule

// File: tb/tb_simd_wakeup_ctrl.sv
// tb_simd_wakeup_ctrl: directed timing scenarios with literal expectations,
// followed by a randomized run checked against a behavioural slot model.
module tb_simd_wakeup_ctrl;
  localparam int LANES = 4, RS_SIZE = 4, IDX_W = 2, LANE_W = 2, DLY_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  simd_wakeup_ctrl_if #(.LANES(LANES), .IDX_W(IDX_W), .LANE_W(LANE_W), .DLY_W(DLY_W)) bus ();

  simd_wakeup_ctrl #(.LANES(LANES), .RS_SIZE(RS_SIZE), .IDX_W(IDX_W), .LANE_W(LANE_W), .DLY_W(DLY_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: per-slot outstanding tag and cycles left until ready.
  bit m_pend [LANES][RS_SIZE];
  int m_rem  [LANES][RS_SIZE];
  bit m_vld  [LANES];
  int m_idx  [LANES];
  bit m_err;

  function automatic void model_clear();
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < RS_SIZE; i++) begin m_pend[l][i] = 0; m_rem[l][i] = 0; end
      m_vld[l] = 0; m_idx[l] = 0;
    end
    m_err = 0;
  endfunction

  function automatic void model_step();
    int sel [LANES];
    int il, ii;
    bit coll;
    il = int'(bus.issue_lane);
    ii = int'(bus.issue_rs_idx);
    for (int l = 0; l < LANES; l++) begin
      sel[l] = -1;
      if (!bus.stall)
        for (int i = 0; i < RS_SIZE; i++)
          if (sel[l] < 0 && m_pend[l][i] && m_rem[l][i] == 0) sel[l] = i;
    end
    coll = bus.issue_valid && il < LANES && m_pend[il][ii] && sel[il] != ii;
    for (int l = 0; l < LANES; l++)
      for (int i = 0; i < RS_SIZE; i++)
        if (sel[l] == i) m_pend[l][i] = 0;
        else if (!bus.stall && m_pend[l][i] && m_rem[l][i] > 0) m_rem[l][i]--;
    if (bus.issue_valid && il < LANES) begin
      m_pend[il][ii] = 1;
      m_rem[il][ii]  = int'(bus.issue_delay);
    end
    for (int l = 0; l < LANES; l++) begin
      m_vld[l] = (sel[l] >= 0);
      if (sel[l] >= 0) m_idx[l] = sel[l];
    end
    if (coll) m_err = 1;
    else if (bus.clear_err) m_err = 0;
  endfunction

  function automatic logic [LANES-1:0] vld_vec();
    logic [LANES-1:0] v;
    for (int l = 0; l < LANES; l++) v[l] = bus.mark_ready_valid[l];
    return v;
  endfunction

  // One clock edge; the model sees the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_clear();
    else model_step();
    #1;
  endtask

  task automatic set_issue(input bit v, input int l, input int i, input int d);
    bus.issue_valid  = v;
    bus.issue_lane   = LANE_W'(l);
    bus.issue_rs_idx = IDX_W'(i);
    bus.issue_delay  = DLY_W'(d);
  endtask

  task automatic test_reset();
    set_issue(0, 0, 0, 0);
    bus.stall = 0; bus.clear_err = 0;
    reset = 0;
    model_clear();
    #12;
    total++; if (vld_vec() !== 4'b0000) begin bad++; $display("FAIL reset_vld: got=%b want=0000", vld_vec()); end
    for (int l = 0; l < LANES; l++) begin
      total++; if (bus.mark_ready_idx[l] !== 2'd0) begin bad++; $display("FAIL reset_idx lane%0d: got=%0d want=0", l, bus.mark_ready_idx[l]); end
    end
    total++; if (bus.lane_busy !== 4'b0000) begin bad++; $display("FAIL reset_busy: got=%b want=0000", bus.lane_busy); end
    total++; if (bus.collision_err !== 1'b0) begin bad++; $display("FAIL reset_err: got=%b want=0", bus.collision_err); end
    reset = 1;
    tick();
  endtask

  task automatic test_basic_latency();
    set_issue(1, 1, 2, 3);
    tick();
    set_issue(0, 0, 0, 0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++; if (vld_vec() !== 4'b0000 || bus.lane_busy[1] !== 1'b1) begin bad++; $display("FAIL basic_wait edge%0d: vld=%b busy=%b want vld=0000 busy1=1", e, vld_vec(), bus.lane_busy); end
    end
    tick();
    total++; if (vld_vec() !== 4'b0010 || bus.mark_ready_idx[1] !== 2'd2) begin bad++; $display("FAIL basic_pulse: vld=%b idx=%0d want vld=0010 idx=2", vld_vec(), bus.mark_ready_idx[1]); end
    total++; if (bus.lane_busy !== 4'b0000) begin bad++; $display("FAIL basic_busy_fall: got=%b want=0000", bus.lane_busy); end
    tick();
    total++; if (vld_vec() !== 4'b0000) begin bad++; $display("FAIL basic_single: vld=%b want=0000", vld_vec()); end
  endtask

  task automatic test_zero_delay();
    set_issue(1, 0, 3, 0);
    tick();
    set_issue(1, 0, 1, 0);
    tick();
    set_issue(0, 0, 0, 0);
    total++; if (vld_vec() !== 4'b0001 || bus.mark_ready_idx[0] !== 2'd3) begin bad++; $display("FAIL d0_first: vld=%b idx=%0d want vld=0001 idx=3", vld_vec(), bus.mark_ready_idx[0]); end
    tick();
    total++; if (vld_vec() !== 4'b0001 || bus.mark_ready_idx[0] !== 2'd1) begin bad++; $display("FAIL d0_second: vld=%b idx=%0d want vld=0001 idx=1", vld_vec(), bus.mark_ready_idx[0]); end
    tick();
    total++; if (vld_vec() !== 4'b0000 || bus.mark_ready_idx[0] !== 2'd1) begin bad++; $display("FAIL d0_idle: vld=%b idx=%0d want vld=0000 idx=1 held", vld_vec(), bus.mark_ready_idx[0]); end
  endtask

  task automatic test_contention();
    set_issue(1, 2, 1, 2);
    tick();
    set_issue(1, 2, 0, 1);
    tick();
    set_issue(0, 0, 0, 0);
    tick();
    total++; if (vld_vec() !== 4'b0000) begin bad++; $display("FAIL cont_early: vld=%b want=0000", vld_vec()); end
    tick();
    total++; if (vld_vec() !== 4'b0100 || bus.mark_ready_idx[2] !== 2'd0) begin bad++; $display("FAIL cont_first: vld=%b idx=%0d want vld=0100 idx=0", vld_vec(), bus.mark_ready_idx[2]); end
    tick();
    total++; if (vld_vec() !== 4'b0100 || bus.mark_ready_idx[2] !== 2'd1) begin bad++; $display("FAIL cont_second: vld=%b idx=%0d want vld=0100 idx=1", vld_vec(), bus.mark_ready_idx[2]); end
    tick();
    total++; if (vld_vec() !== 4'b0000 || bus.lane_busy[2] !== 1'b0) begin bad++; $display("FAIL cont_done: vld=%b busy=%b want vld=0000 busy2=0", vld_vec(), bus.lane_busy); end
  endtask

  task automatic test_stall();
    set_issue(1, 3, 0, 2);
    tick();
    set_issue(0, 0, 0, 0);
    tick();
    bus.stall = 1;
    for (int s = 0; s < 5; s++) begin
      tick();
      total++; if (vld_vec() !== 4'b0000 || bus.lane_busy[3] !== 1'b1) begin bad++; $display("FAIL stall_hold cyc%0d: vld=%b busy=%b want vld=0000 busy3=1", s, vld_vec(), bus.lane_busy); end
    end
    bus.stall = 0;
    tick();
    total++; if (vld_vec() !== 4'b0000) begin bad++; $display("FAIL stall_resume_early: vld=%b want=0000", vld_vec()); end
    tick();
    total++; if (vld_vec() !== 4'b1000 || bus.mark_ready_idx[3] !== 2'd0) begin bad++; $display("FAIL stall_pulse: vld=%b idx=%0d want vld=1000 idx=0", vld_vec(), bus.mark_ready_idx[3]); end
    tick();
  endtask

  task automatic test_collision();
    int pulses;
    set_issue(1, 1, 1, 5);
    tick();
    set_issue(1, 1, 1, 2);
    tick();
    set_issue(0, 0, 0, 0);
    total++; if (bus.collision_err !== 1'b1) begin bad++; $display("FAIL coll_set: got=%b want=1", bus.collision_err); end
    pulses = 0;
    for (int e = 2; e <= 8; e++) begin
      tick();
      if (bus.mark_ready_valid[1]) begin
        pulses++;
        total++; if (e != 4) begin bad++; $display("FAIL coll_timing: pulse after edge %0d want edge 4", e); end
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL coll_pulses: got=%0d want=1", pulses); end
    bus.clear_err = 1;
    tick();
    bus.clear_err = 0;
    total++; if (bus.collision_err !== 1'b0) begin bad++; $display("FAIL coll_clear: got=%b want=0", bus.collision_err); end
    // Collision and clear on the same edge: the set must win.
    set_issue(1, 2, 3, 3);
    tick();
    set_issue(1, 2, 3, 3);
    bus.clear_err = 1;
    tick();
    set_issue(0, 0, 0, 0);
    bus.clear_err = 0;
    total++; if (bus.collision_err !== 1'b1) begin bad++; $display("FAIL coll_set_wins: got=%b want=1", bus.collision_err); end
    for (int k = 0; k < 6; k++) tick();
    bus.clear_err = 1;
    tick();
    bus.clear_err = 0;
    // Re-issue on the retire edge is legal and yields a second pulse.
    set_issue(1, 0, 2, 0);
    tick();
    set_issue(1, 0, 2, 1);
    tick();
    set_issue(0, 0, 0, 0);
    total++; if (bus.collision_err !== 1'b0 || vld_vec() !== 4'b0001 || bus.mark_ready_idx[0] !== 2'd2) begin bad++; $display("FAIL retire_reissue_first: err=%b vld=%b idx=%0d want err=0 vld=0001 idx=2", bus.collision_err, vld_vec(), bus.mark_ready_idx[0]); end
    tick();
    total++; if (vld_vec() !== 4'b0000 || bus.lane_busy[0] !== 1'b1) begin bad++; $display("FAIL retire_reissue_gap: vld=%b busy=%b want vld=0000 busy0=1", vld_vec(), bus.lane_busy); end
    tick();
    total++; if (vld_vec() !== 4'b0001 || bus.mark_ready_idx[0] !== 2'd2 || bus.collision_err !== 1'b0) begin bad++; $display("FAIL retire_reissue_second: vld=%b idx=%0d err=%b want vld=0001 idx=2 err=0", vld_vec(), bus.mark_ready_idx[0], bus.collision_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_issue(1, 0, 0, 9); tick();
    set_issue(1, 1, 1, 9); tick();
    set_issue(1, 2, 2, 9); tick();
    set_issue(1, 3, 3, 0); tick();
    set_issue(1, 3, 0, 9); tick();
    set_issue(0, 0, 0, 0);
    total++; if (vld_vec() !== 4'b1000 || bus.lane_busy !== 4'b1111) begin bad++; $display("FAIL rstmid_pre: vld=%b busy=%b want vld=1000 busy=1111", vld_vec(), bus.lane_busy); end
    #2 reset = 0;
    #1;
    total++; if (vld_vec() !== 4'b0000 || bus.lane_busy !== 4'b0000) begin bad++; $display("FAIL rstmid_async: vld=%b busy=%b want 0000/0000", vld_vec(), bus.lane_busy); end
    total++; if (bus.mark_ready_idx[3] !== 2'd0) begin bad++; $display("FAIL rstmid_idx: got=%0d want=0", bus.mark_ready_idx[3]); end
    tick();
    reset = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++; if (vld_vec() !== 4'b0000 || bus.lane_busy !== 4'b0000) begin bad++; $display("FAIL rstmid_after cyc%0d: vld=%b busy=%b want 0000/0000", k, vld_vec(), bus.lane_busy); end
    end
  endtask

  task automatic test_random();
    logic [LANES-1:0] exp_busy;
    for (int c = 0; c < 400; c++) begin
      set_issue(($urandom_range(0, 99) < 45), $urandom_range(0, LANES - 1), $urandom_range(0, RS_SIZE - 1), $urandom_range(0, 6));
      bus.stall     = ($urandom_range(0, 99) < 12);
      bus.clear_err = ($urandom_range(0, 99) < 6);
      tick();
      for (int l = 0; l < LANES; l++) begin
        total++; if (bus.mark_ready_valid[l] !== m_vld[l] || int'(bus.mark_ready_idx[l]) != m_idx[l]) begin bad++; $display("FAIL rand_lane cyc%0d lane%0d: vld=%b idx=%0d want vld=%b idx=%0d", c, l, bus.mark_ready_valid[l], bus.mark_ready_idx[l], m_vld[l], m_idx[l]); end
      end
      exp_busy = '0;
      for (int l = 0; l < LANES; l++)
        for (int i = 0; i < RS_SIZE; i++) if (m_pend[l][i]) exp_busy[l] = 1'b1;
      total++; if (bus.lane_busy !== exp_busy || bus.collision_err !== m_err) begin bad++; $display("FAIL rand_status cyc%0d: busy=%b err=%b want busy=%b err=%b", c, bus.lane_busy, bus.collision_err, exp_busy, m_err); end
    end
    set_issue(0, 0, 0, 0);
    bus.stall = 0; bus.clear_err = 0;
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_zero_delay();
    test_contention();
    test_stall();
    test_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
